// File: rtl/dom1_romulusn_ctrl_pkg.sv
// Shared encodings and constants for the DOM-1 Romulus-N sequencing controller.
// The round-constant LFSR step lives here so every user applies the same update.
package dom1_romulusn_ctrl_pkg;

    localparam int D         = 2;
    localparam int KEY_WORDS = 4 * D;
    localparam int BLK_WORDS = 4;
    localparam int ROUNDS    = 40;
    localparam int RND_CYC   = 5;

    localparam logic [4:0] TBCEN_COMMIT = 5'b10000;
    localparam logic [5:0] RC_INIT      = 6'h00;

    typedef enum logic [2:0] {
        OP_LDKEY   = 3'd0,
        OP_LDTWK   = 3'd1,
        OP_LDST    = 3'd2,
        OP_RUN     = 3'd3,
        OP_INC     = 3'd4,
        OP_OUT     = 3'd5,
        OP_CLRST   = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_t;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LDKEY = 4'd1,
        ST_LDTWK = 4'd2,
        ST_LDST  = 4'd3,
        ST_RUN   = 4'd4,
        ST_CRCT  = 4'd5,
        ST_INC   = 4'd6,
        ST_OUT   = 4'd7,
        ST_CLRST = 4'd8
    } state_t;

    // Skinny 6-bit round-constant LFSR step.
    function automatic logic [5:0] rc_next(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/dom1_romulusn_ctrl_rnd_seq.sv
// Round/stage sequencer for one 40-round DOM Skinny invocation.
// rc holds the constant of the round in progress and is cleared when the run ends.
module dom1_rnd_seq
    import dom1_romulusn_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run_start,
    output logic [4:0] tbcen,
    output logic [5:0] rnd_cnst,
    output logic       commit,
    output logic       last_commit
);

    localparam logic [2:0] S_LAST = 3'(RND_CYC - 1);
    localparam logic [5:0] R_LAST = 6'(ROUNDS - 1);

    logic       running;
    logic [5:0] rnd;
    logic [2:0] stage;
    logic [5:0] rc;

    // Counter and LFSR state; a run always starts from round 0, stage 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            rnd     <= 6'd0;
            stage   <= 3'd0;
            rc      <= RC_INIT;
        end else if (run_start) begin
            running <= 1'b1;
            rnd     <= 6'd0;
            stage   <= 3'd0;
            rc      <= rc_next(RC_INIT);
        end else if (running) begin
            if (stage == S_LAST) begin
                stage <= 3'd0;
                if (rnd == R_LAST) begin
                    running <= 1'b0;
                    rnd     <= 6'd0;
                    rc      <= RC_INIT;
                end else begin
                    rnd <= rnd + 6'd1;
                    rc  <= rc_next(rc);
                end
            end else begin
                stage <= stage + 3'd1;
            end
        end
    end

    // Stage decode: one-hot DOM stage enables, then the commit cycle.
    always_comb begin
        tbcen  = 5'b00000;
        commit = 1'b0;
        if (running) begin
            if (stage == S_LAST) begin
                tbcen  = TBCEN_COMMIT;
                commit = 1'b1;
            end else begin
                tbcen = 5'b00001 << stage;
            end
        end else begin
            tbcen = 5'b00000;
        end
    end

    assign last_commit = commit && (rnd == R_LAST);
    assign rnd_cnst    = rc;

endmodule

// File: rtl/dom1_romulusn_ctrl.sv
// Sequencing controller for the DOM-1 protected Romulus-N datapath: loads
// key/tweak/state words, runs the TBC, rewinds key schedule and streams state out.
module dom1_romulusn_ctrl
    import dom1_romulusn_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_dom,
    input  logic [3:0] cmd_dec,
    input  logic       cmd_tk1,
    input  logic       sdi_valid,
    output logic       sdi_ready,
    input  logic       pdi_valid,
    output logic       pdi_ready,
    output logic       pdo_valid,
    input  logic       pdo_ready,
    output logic       swr,
    output logic       srst,
    output logic       kwr,
    output logic       ken,
    output logic       kcrct,
    output logic       twr,
    output logic       ten,
    output logic       tcrct,
    output logic       crst,
    output logic       cen,
    output logic       ccrct,
    output logic       correct_cnt,
    output logic       tk1s,
    output logic [5:0] rnd_cnst,
    output logic [4:0] tbcen,
    output logic [7:0] domain,
    output logic [3:0] decrypt,
    output logic       busy
);

    localparam logic [2:0] WC_KEY_LAST = 3'(KEY_WORDS - 1);
    localparam logic [2:0] WC_BLK_LAST = 3'(BLK_WORDS - 1);

    state_t     state;
    state_t     state_nx;
    logic [2:0] wc;
    logic [7:0] dom_lat;
    logic [3:0] dec_lat;
    logic       tk1_lat;
    logic       crst_pend;

    logic       cmd_acc;
    logic       op_legal;
    logic       sdi_hs;
    logic       pdi_hs;
    logic       pdo_hs;
    logic       wc_last;
    logic       run_start;
    logic [4:0] seq_tbcen;
    logic       seq_commit;
    logic       seq_last_commit;

    // Handshakes decode straight from state so the ready outputs never loop back.
    assign cmd_acc   = cmd_valid && (state == ST_IDLE);
    assign op_legal  = (cmd_op != OP_ILLEGAL);
    assign sdi_hs    = sdi_valid && (state == ST_LDKEY);
    assign pdi_hs    = pdi_valid && ((state == ST_LDTWK) || (state == ST_LDST));
    assign pdo_hs    = pdo_ready && (state == ST_OUT);
    assign wc_last   = (state == ST_LDKEY) ? (wc == WC_KEY_LAST) : (wc == WC_BLK_LAST);
    assign run_start = cmd_acc && (cmd_op == OP_RUN);

    dom1_rnd_seq u_rnd_seq (
        .clk         (clk),
        .rst         (rst),
        .run_start   (run_start),
        .tbcen       (seq_tbcen),
        .rnd_cnst    (rnd_cnst),
        .commit      (seq_commit),
        .last_commit (seq_last_commit)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; an illegal op is consumed without leaving IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (cmd_acc) begin
                    case (op_t'(cmd_op))
                        OP_LDKEY: state_nx = ST_LDKEY;
                        OP_LDTWK: state_nx = ST_LDTWK;
                        OP_LDST:  state_nx = ST_LDST;
                        OP_RUN:   state_nx = ST_RUN;
                        OP_INC:   state_nx = ST_INC;
                        OP_OUT:   state_nx = ST_OUT;
                        OP_CLRST: state_nx = ST_CLRST;
                        default:  state_nx = ST_IDLE;
                    endcase
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LDKEY: state_nx = (sdi_hs && wc_last) ? ST_IDLE : ST_LDKEY;
            ST_LDTWK: state_nx = (pdi_hs && wc_last) ? ST_IDLE : ST_LDTWK;
            ST_LDST:  state_nx = (pdi_hs && wc_last) ? ST_IDLE : ST_LDST;
            ST_RUN:   state_nx = seq_last_commit ? ST_CRCT : ST_RUN;
            ST_OUT:   state_nx = (pdo_hs && wc_last) ? ST_IDLE : ST_OUT;
            ST_CRCT:  state_nx = ST_IDLE;
            ST_INC:   state_nx = ST_IDLE;
            ST_CLRST: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Word counter and command field latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc      <= 3'd0;
            dom_lat <= 8'h00;
            dec_lat <= 4'h0;
            tk1_lat <= 1'b0;
        end else begin
            if (sdi_hs || pdi_hs || pdo_hs) begin
                wc <= wc_last ? 3'd0 : (wc + 3'd1);
            end
            if (cmd_acc && op_legal) begin
                dom_lat <= cmd_dom;
                dec_lat <= cmd_dec;
                tk1_lat <= cmd_tk1;
            end
        end
    end

    // Counter-reset pulse: one cycle right after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crst_pend <= 1'b1;
        end else begin
            crst_pend <= 1'b0;
        end
    end

    // Output decode; every strobe defaults low.
    always_comb begin
        cmd_ready   = 1'b0;
        sdi_ready   = 1'b0;
        pdi_ready   = 1'b0;
        pdo_valid   = 1'b0;
        swr         = 1'b0;
        srst        = 1'b0;
        kwr         = 1'b0;
        ken         = 1'b0;
        kcrct       = 1'b0;
        twr         = 1'b0;
        ten         = 1'b0;
        tcrct       = 1'b0;
        cen         = 1'b0;
        ccrct       = 1'b0;
        correct_cnt = 1'b0;
        tk1s        = 1'b0;
        tbcen       = 5'b00000;
        decrypt     = 4'h0;
        busy        = (state != ST_IDLE);
        crst        = crst_pend && !rst;
        case (state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_LDKEY: begin
                sdi_ready = 1'b1;
                kwr       = sdi_hs;
                ken       = sdi_hs;
            end
            ST_LDTWK: begin
                pdi_ready = 1'b1;
                twr       = pdi_hs;
                ten       = pdi_hs;
            end
            ST_LDST: begin
                pdi_ready = 1'b1;
                swr       = pdi_hs;
                tbcen     = pdi_hs ? TBCEN_COMMIT : 5'b00000;
            end
            ST_CLRST: begin
                srst  = 1'b1;
                tbcen = TBCEN_COMMIT;
            end
            ST_RUN: begin
                tbcen = seq_tbcen;
                tk1s  = tk1_lat;
                ken   = seq_commit;
                ten   = seq_commit;
                cen   = seq_commit;
            end
            ST_CRCT: begin
                kcrct = 1'b1;
                tcrct = 1'b1;
                ccrct = 1'b1;
                ken   = 1'b1;
                ten   = 1'b1;
                cen   = 1'b1;
            end
            ST_INC: begin
                ccrct       = 1'b1;
                cen         = 1'b1;
                correct_cnt = 1'b1;
            end
            ST_OUT: begin
                pdo_valid = 1'b1;
                decrypt   = dec_lat;
                tbcen     = pdo_hs ? TBCEN_COMMIT : 5'b00000;
            end
            default: busy = 1'b1;
        endcase
    end

    assign domain = dom_lat;

endmodule

// File: tb/tb_dom1_romulusn_ctrl.sv
// Scoreboard bench for dom1_romulusn_ctrl: stimulus pushes the expected strobe
// vectors, a negedge monitor pops one per cycle in which the DUT emits anything.
module tb_dom1_romulusn_ctrl;

    localparam logic [12:0] S_SWR  = 13'h1000;
    localparam logic [12:0] S_SRST = 13'h0800;
    localparam logic [12:0] S_KWR  = 13'h0400;
    localparam logic [12:0] S_KEN  = 13'h0200;
    localparam logic [12:0] S_KCR  = 13'h0100;
    localparam logic [12:0] S_TWR  = 13'h0080;
    localparam logic [12:0] S_TEN  = 13'h0040;
    localparam logic [12:0] S_TCR  = 13'h0020;
    localparam logic [12:0] S_CRST = 13'h0010;
    localparam logic [12:0] S_CEN  = 13'h0008;
    localparam logic [12:0] S_CCR  = 13'h0004;
    localparam logic [12:0] S_CCNT = 13'h0002;
    localparam logic [12:0] S_TK1S = 13'h0001;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_tk1;
    logic [2:0] cmd_op;
    logic [7:0] cmd_dom;
    logic [3:0] cmd_dec;
    logic       sdi_valid, sdi_ready, pdi_valid, pdi_ready, pdo_valid, pdo_ready;
    logic       swr, srst, kwr, ken, kcrct, twr, ten, tcrct, crst, cen, ccrct, correct_cnt, tk1s;
    logic [5:0] rnd_cnst;
    logic [4:0] tbcen;
    logic [7:0] domain;
    logic [3:0] decrypt;
    logic       busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  cur_dom = 8'h00;
    logic [36:0] exp_q[$];

    dom1_romulusn_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dom(cmd_dom), .cmd_dec(cmd_dec), .cmd_tk1(cmd_tk1),
        .sdi_valid(sdi_valid), .sdi_ready(sdi_ready), .pdi_valid(pdi_valid),
        .pdi_ready(pdi_ready), .pdo_valid(pdo_valid), .pdo_ready(pdo_ready),
        .swr(swr), .srst(srst), .kwr(kwr), .ken(ken), .kcrct(kcrct), .twr(twr),
        .ten(ten), .tcrct(tcrct), .crst(crst), .cen(cen), .ccrct(ccrct),
        .correct_cnt(correct_cnt), .tk1s(tk1s), .rnd_cnst(rnd_cnst), .tbcen(tbcen),
        .domain(domain), .decrypt(decrypt), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] observed();
        return {swr, srst, kwr, ken, kcrct, twr, ten, tcrct, crst, cen, ccrct,
                correct_cnt, tk1s, rnd_cnst, tbcen, decrypt, pdo_valid, domain};
    endfunction

    task automatic push(input logic [12:0] str, input logic [5:0] rc, input logic [4:0] tb,
                        input logic [3:0] dec, input logic pv);
        exp_q.push_back({str, rc, tb, dec, pv, cur_dom});
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] dom, input logic [3:0] dec,
                         input logic tk1);
        int n = 0;
        while (!cmd_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL cmd_ready_timeout actual=0 required=1");
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_dom = dom; cmd_dec = dec; cmd_tk1 = tk1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        cur_dom = 8'h00;
        push(S_CRST, 6'h00, 5'b00000, 4'h0, 1'b0);
        rst = 1'b0;
    endtask

    // Monitor: every cycle with any strobe or pdo_valid consumes one expectation.
    initial begin
        logic [36:0] obs;
        logic [36:0] req;
        forever begin
            @(negedge clk);
            if (!rst) begin
                obs = observed();
                if (obs[36:8] != 29'd0) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_event actual=%h required=none", obs);
                    end else begin
                        req = exp_q.pop_front();
                        if (obs !== req) begin
                            n_err++;
                            $display("FAIL event actual=%h required=%h", obs, req);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] rc;
        logic [4:0] tb;
        int         n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_dom = 8'h00; cmd_dec = 4'h0;
        cmd_tk1 = 1'b0; sdi_valid = 1'b0; pdi_valid = 1'b0; pdo_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_strobes", 64'(observed()), 64'd0);
        release_reset();

        // LDKEY, sdi_valid toggling
        repeat (2) @(posedge clk); #1;
        cur_dom = 8'h5A;
        repeat (8) push(S_KWR | S_KEN, 6'h00, 5'b00000, 4'h0, 1'b0);
        issue(3'd0, 8'h5A, 4'h0, 1'b0);
        chk("ldkey_cmd_ready_low", 64'(cmd_ready), 64'd0);
        chk("ldkey_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 15; i++) begin
            sdi_valid = ~i[0];
            @(posedge clk); #1;
        end
        sdi_valid = 1'b0;
        chk("ldkey_done_ready", 64'(cmd_ready), 64'd1);

        // LDTWK, continuous words
        cur_dom = 8'h21;
        repeat (4) push(S_TWR | S_TEN, 6'h00, 5'b00000, 4'h0, 1'b0);
        issue(3'd1, 8'h21, 4'h0, 1'b0);
        pdi_valid = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        pdi_valid = 1'b0;
        chk("ldtwk_done_ready", 64'(cmd_ready), 64'd1);

        // LDST with one gap cycle
        cur_dom = 8'h32;
        repeat (4) push(S_SWR, 6'h00, 5'b10000, 4'h0, 1'b0);
        issue(3'd2, 8'h32, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            pdi_valid = (i != 2);
            @(posedge clk); #1;
        end
        pdi_valid = 1'b0;
        chk("ldst_done_ready", 64'(cmd_ready), 64'd1);

        // CLRST
        cur_dom = 8'h43;
        push(S_SRST, 6'h00, 5'b10000, 4'h0, 1'b0);
        issue(3'd6, 8'h43, 4'h0, 1'b0);
        @(posedge clk); #1;
        chk("clrst_done_ready", 64'(cmd_ready), 64'd1);

        // Full RUN with TK1, then the CRCT rewind cycle
        cur_dom = 8'h54;
        rc = 6'h00;
        for (int r = 0; r < 40; r++) begin
            rc = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
            for (int s = 0; s < 5; s++) begin
                tb = 5'b00001 << s;
                if (s < 4) push(S_TK1S, rc, tb, 4'h0, 1'b0);
                else       push(S_TK1S | S_KEN | S_TEN | S_CEN, rc, 5'b10000, 4'h0, 1'b0);
            end
        end
        push(S_KCR | S_TCR | S_CCR | S_KEN | S_TEN | S_CEN, 6'h00, 5'b00000, 4'h0, 1'b0);
        issue(3'd3, 8'h54, 4'h0, 1'b1);
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("run_plus_crct_cycles", 64'(n), 64'd201);

        // INC
        cur_dom = 8'h04;
        push(S_CEN | S_CCR | S_CCNT, 6'h00, 5'b00000, 4'h0, 1'b0);
        issue(3'd4, 8'h04, 4'h0, 1'b0);
        @(posedge clk); #1;
        chk("inc_done_ready", 64'(cmd_ready), 64'd1);

        // Illegal op: dropped, domain not relatched
        issue(3'd7, 8'hAA, 4'h3, 1'b1);
        chk("illegal_ready", 64'(cmd_ready), 64'd1);
        chk("illegal_busy", 64'(busy), 64'd0);
        chk("illegal_domain", 64'(domain), 64'h04);

        // OUT under backpressure
        repeat (3) push(13'h0000, 6'h00, 5'b00000, 4'hF, 1'b1);
        repeat (4) push(13'h0000, 6'h00, 5'b10000, 4'hF, 1'b1);
        issue(3'd5, 8'h04, 4'hF, 1'b0);
        for (int i = 0; i < 7; i++) begin
            pdo_ready = (i >= 3);
            @(posedge clk); #1;
        end
        pdo_ready = 1'b0;
        chk("out_decrypt_cleared", 64'(decrypt), 64'd0);
        chk("out_pdo_valid_low", 64'(pdo_valid), 64'd0);
        chk("out_done_ready", 64'(cmd_ready), 64'd1);

        // Reset at round 17 of a RUN without TK1
        cur_dom = 8'h11;
        rc = 6'h00;
        for (int r = 0; r < 17; r++) begin
            rc = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
            for (int s = 0; s < 5; s++) begin
                tb = 5'b00001 << s;
                if (s < 4) push(13'h0000, rc, tb, 4'h0, 1'b0);
                else       push(S_KEN | S_TEN | S_CEN, rc, 5'b10000, 4'h0, 1'b0);
            end
        end
        issue(3'd3, 8'h11, 4'h0, 1'b0);
        repeat (85) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_strobes", 64'(observed()), 64'd0);
        chk("midrst_queue_drained", 64'(exp_q.size()), 64'd0);
        release_reset();

        // Fresh LDKEY after the abort
        cur_dom = 8'h66;
        repeat (8) push(S_KWR | S_KEN, 6'h00, 5'b00000, 4'h0, 1'b0);
        issue(3'd0, 8'h66, 4'h0, 1'b0);
        sdi_valid = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        sdi_valid = 1'b0;
        chk("post_rst_ldkey_ready", 64'(cmd_ready), 64'd1);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
